// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction-fetch
// and data-access sides, D-priority with bounded starvation of I.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int MEM_LATENCY  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  output logic                 i_wait,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 d_wait,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0]           CNT_LOAD   = 4'(MEM_LATENCY - 1);
  localparam logic [2:0]           STREAK_MAX = 3'(STARVE_LIMIT);
  localparam logic [WORD_SIZE-1:0] ZERO_W     = {WORD_SIZE{1'b0}};

  state_t               state_r;
  logic [3:0]           cnt_r;
  logic [2:0]           streak_r;
  logic                 we_r;
  logic                 owner_r;
  logic [WORD_SIZE-1:0] addr_r;
  logic [WORD_SIZE-1:0] wdata_r;
  logic [WORD_SIZE-1:0] i_rdata_r;
  logic [WORD_SIZE-1:0] d_rdata_r;
  logic                 i_done_r;
  logic                 d_done_r;
  logic                 mem_read_r;
  logic                 mem_write_r;
  logic                 grant_d_s;

  // Arbitration: D wins a contest unless I has already lost STARVE_LIMIT in a row.
  always_comb begin
    grant_d_s = 1'b0;
    if (d_req && i_req) begin
      grant_d_s = (streak_r != STREAK_MAX);
    end else if (d_req) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
  end

  // Access sequencer: grant in IDLE, drive memory for MEM_LATENCY cycles, pulse done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      streak_r    <= 3'd0;
      we_r        <= 1'b0;
      owner_r     <= 1'b0;
      addr_r      <= ZERO_W;
      wdata_r     <= ZERO_W;
      i_rdata_r   <= ZERO_W;
      d_rdata_r   <= ZERO_W;
      i_done_r    <= 1'b0;
      d_done_r    <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          i_done_r <= 1'b0;
          d_done_r <= 1'b0;
          if (i_req || d_req) begin
            state_r <= ACCESS;
            cnt_r   <= CNT_LOAD;
            owner_r <= grant_d_s;
            if (grant_d_s) begin
              addr_r      <= d_addr;
              wdata_r     <= d_wdata;
              we_r        <= d_we;
              mem_read_r  <= ~d_we;
              mem_write_r <= d_we;
              // Only a D win over a waiting I counts toward the starvation streak.
              if (i_req && (streak_r != STREAK_MAX)) begin
                streak_r <= streak_r + 3'd1;
              end else if (i_req) begin
                streak_r <= streak_r;
              end else begin
                streak_r <= 3'd0;
              end
            end else begin
              addr_r      <= i_addr;
              wdata_r     <= ZERO_W;
              we_r        <= 1'b0;
              mem_read_r  <= 1'b1;
              mem_write_r <= 1'b0;
              streak_r    <= 3'd0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt_r == 4'd0) begin
            state_r     <= DONE;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            if (owner_r) begin
              d_done_r <= 1'b1;
            end else begin
              i_done_r <= 1'b1;
            end
            if (!we_r && owner_r) begin
              d_rdata_r <= mem_rdata;
            end else if (!we_r) begin
              i_rdata_r <= mem_rdata;
            end else begin
              d_rdata_r <= d_rdata_r;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE: begin
          i_done_r <= 1'b0;
          d_done_r <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          i_done_r    <= 1'b0;
          d_done_r    <= 1'b0;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
        end
      endcase
    end
  end

  assign i_rdata   = i_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign i_done    = i_done_r;
  assign d_done    = d_done_r;
  assign i_wait    = i_req & ~i_done_r;
  assign d_wait    = d_req & ~d_done_r;
  assign mem_read  = mem_read_r;
  assign mem_write = mem_write_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign owner     = owner_r;

endmodule
